dvi_pixel_packer: RTL and testbench

//  Upstream feeder for the DVI output stage. Accepts the 8-bit byte stream from the

---
 rtl/dvi_pixel_packer_pkg.sv | 39 +++
 rtl/dvi_pixel_fifo.sv | 60 ++++++
 rtl/dvi_pixel_packer.sv | 117 +++++++++++
 tb/tb_dvi_pixel_packer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_pixel_packer_pkg.sv
// Shared pixel constants, phase encoding and FIFO entry layout for the DVI pixel packer.
package dvi_pixel_packer_pkg;

  localparam int PIXEL_W = 24;
  localparam int ENTRY_W = PIXEL_W + 1;
  localparam int R_LSB   = 16;
  localparam int G_LSB   = 8;
  localparam int B_LSB   = 0;

  typedef enum logic [1:0] {
    PH_BYTE0 = 2'd0,
    PH_BYTE1 = 2'd1,
    PH_BYTE2 = 2'd2
  } phase_e;

  typedef struct packed {
    logic               sof;
    logic [PIXEL_W-1:0] rgb;
  } fifo_entry_t;

  // Places the three bytes of a pixel into {R,G,B}; bgr selects B,G,R arrival order.
  function automatic logic [PIXEL_W-1:0] pack_rgb(input logic [7:0] first,
                                                  input logic [7:0] mid,
                                                  input logic [7:0] last,
                                                  input logic       bgr);
    logic [PIXEL_W-1:0] px;
    px = '0;
    px[G_LSB +: 8] = mid;
    if (bgr) begin
      px[B_LSB +: 8] = first;
      px[R_LSB +: 8] = last;
    end else begin
      px[R_LSB +: 8] = first;
      px[B_LSB +: 8] = last;
    end
    return px;
  endfunction

endpackage

// File: rtl/dvi_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever empty=0.
module dvi_pixel_fifo #(
  parameter int WIDTH  = 25,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Reads as zero when empty so the pixel bus is quiet in reset and between frames.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; empty/level gate every read, so stale words are never seen.
  always_ff @(posedge clk_100) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/dvi_pixel_packer.sv
// Packs a byte stream into 24-bit RGB pixels with a start-of-frame marker and buffers
// them in a FWFT FIFO for the DVI output stage.
module dvi_pixel_packer
  import dvi_pixel_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int BYTE_ORDER = 0
) (
  input  logic                clk_100,
  input  logic                reset,
  input  logic [7:0]          byte_data,
  input  logic                byte_valid,
  input  logic                byte_sof,
  output logic                byte_ready,
  output logic [PIXEL_W-1:0]  pixel_data,
  output logic                pixel_valid,
  output logic                pixel_sof,
  input  logic                ready,
  output logic [ADDR_W:0]     fifo_level,
  output logic [7:0]          deb
);

  phase_e      phase_q, phase_d;
  logic [7:0]  hold0_q, hold0_d;
  logic [7:0]  hold1_q, hold1_d;
  logic        sof_pend_q, sof_pend_d;
  logic [7:0]  deb_q, deb_d;
  logic        accept;
  logic        push;
  logic        drop;
  logic        fifo_full;
  logic        fifo_empty;
  fifo_entry_t wr_entry;
  fifo_entry_t rd_entry;

  // Depends only on registered phase and FIFO level, never on the downstream ready.
  assign byte_ready = reset & ~((phase_q == PH_BYTE2) & fifo_full);
  assign accept     = byte_valid & byte_ready;

  assign wr_entry.sof = sof_pend_q;
  assign wr_entry.rgb = pack_rgb(hold0_q, hold1_q, byte_data, BYTE_ORDER != 0);

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    phase_d    = phase_q;
    hold0_d    = hold0_q;
    hold1_d    = hold1_q;
    sof_pend_d = sof_pend_q;
    push       = 1'b0;
    drop       = 1'b0;
    if (accept) begin
      if (byte_sof) begin
        hold0_d    = byte_data;
        phase_d    = PH_BYTE1;
        sof_pend_d = 1'b1;
        drop       = (phase_q != PH_BYTE0);
      end else begin
        case (phase_q)
          PH_BYTE0: begin
            hold0_d = byte_data;
            phase_d = PH_BYTE1;
          end
          PH_BYTE1: begin
            hold1_d = byte_data;
            phase_d = PH_BYTE2;
          end
          PH_BYTE2: begin
            push       = 1'b1;
            sof_pend_d = 1'b0;
            phase_d    = PH_BYTE0;
          end
          default: phase_d = PH_BYTE0;
        endcase
      end
    end
    deb_d = (drop && (deb_q != 8'hFF)) ? deb_q + 8'd1 : deb_q;
  end

  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      phase_q    <= PH_BYTE0;
      hold0_q    <= '0;
      hold1_q    <= '0;
      sof_pend_q <= 1'b0;
      deb_q      <= '0;
    end else begin
      phase_q    <= phase_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
      sof_pend_q <= sof_pend_d;
      deb_q      <= deb_d;
    end
  end

  dvi_pixel_fifo #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_100 (clk_100),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (wr_entry),
    .full    (fifo_full),
    .rd_en   (ready),
    .rd_data (rd_entry),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign pixel_valid = ~fifo_empty;
  assign pixel_data  = rd_entry.rgb;
  assign pixel_sof   = rd_entry.sof;
  assign deb         = deb_q;

endmodule

// File: tb/tb_dvi_pixel_packer.sv
// Drives both byte orders from one stream and checks them against a queue-based model.
module tb_dvi_pixel_packer;

  logic        clk_100 = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_sof = 1'b0;
  logic        ready = 1'b0;

  logic        byte_ready_a, byte_ready_b;
  logic [23:0] pixel_data_a, pixel_data_b;
  logic        pixel_valid_a, pixel_valid_b;
  logic        pixel_sof_a, pixel_sof_b;
  logic [4:0]  fifo_level_a, fifo_level_b;
  logic [7:0]  deb_a, deb_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_100 = ~clk_100;

  dvi_pixel_packer #(.FIFO_DEPTH(16), .ADDR_W(4), .BYTE_ORDER(0)) dut_a (
    .clk_100(clk_100), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_sof(byte_sof), .byte_ready(byte_ready_a), .pixel_data(pixel_data_a),
    .pixel_valid(pixel_valid_a), .pixel_sof(pixel_sof_a), .ready(ready),
    .fifo_level(fifo_level_a), .deb(deb_a)
  );

  dvi_pixel_packer #(.FIFO_DEPTH(16), .ADDR_W(4), .BYTE_ORDER(1)) dut_b (
    .clk_100(clk_100), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_sof(byte_sof), .byte_ready(byte_ready_b), .pixel_data(pixel_data_b),
    .pixel_valid(pixel_valid_b), .pixel_sof(pixel_sof_b), .ready(ready),
    .fifo_level(fifo_level_b), .deb(deb_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: entries are {sof, byte0, byte1, byte2} in arrival order.
  logic [24:0] m_q[$];
  int          m_phase = 0;
  logic [7:0]  m_bytes [3];
  logic        m_pend = 1'b0;
  int          m_deb = 0;
  bit          m_acc;
  bit          m_pop;

  function automatic logic [23:0] swap_rb(input logic [23:0] px);
    return {px[7:0], px[15:8], px[23:16]};
  endfunction

  always @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_phase = 0;
      m_pend  = 1'b0;
      m_deb   = 0;
    end else begin
      m_acc = byte_valid && !(m_phase == 2 && m_q.size() == 16);
      m_pop = ready && (m_q.size() > 0);
      if (m_pop) void'(m_q.pop_front());
      if (m_acc) begin
        if (byte_sof) begin
          if (m_phase != 0 && m_deb < 255) m_deb++;
          m_bytes[0] = byte_data;
          m_phase    = 1;
          m_pend     = 1'b1;
        end else begin
          m_bytes[m_phase] = byte_data;
          if (m_phase == 2) begin
            m_q.push_back({m_pend, m_bytes[0], m_bytes[1], m_bytes[2]});
            m_pend  = 1'b0;
            m_phase = 0;
          end else begin
            m_phase++;
          end
        end
      end
    end
  end

  logic        exp_ready;
  logic [24:0] head;

  always @(negedge clk_100) begin
    exp_ready = reset && !(m_phase == 2 && m_q.size() == 16);
    check("byte_ready_a", byte_ready_a, exp_ready);
    check("byte_ready_b", byte_ready_b, exp_ready);
    check("pixel_valid_a", pixel_valid_a, m_q.size() != 0);
    check("pixel_valid_b", pixel_valid_b, m_q.size() != 0);
    check("fifo_level_a", fifo_level_a, m_q.size());
    check("fifo_level_b", fifo_level_b, m_q.size());
    check("deb_a", deb_a, m_deb);
    check("deb_b", deb_b, m_deb);
    head = (m_q.size() != 0) ? m_q[0] : 25'd0;
    check("pixel_data_a", pixel_data_a, head[23:0]);
    check("pixel_data_b", pixel_data_b, swap_rb(head[23:0]));
    check("pixel_sof_a", pixel_sof_a, head[24]);
    check("pixel_sof_b", pixel_sof_b, head[24]);
  end

  // Waits for an edge, then presents new inputs just after it.
  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic r);
    @(posedge clk_100);
    #1;
    byte_valid = v;
    byte_data  = d;
    byte_sof   = s;
    ready      = r;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_100);
    #1 reset = 1'b1;

    // Basic RGB assembly and one-cycle latency.
    drive(1, 8'h11, 0, 1);
    drive(1, 8'h22, 0, 1);
    drive(1, 8'h33, 0, 1);
    drive(0, 8'h00, 0, 1);
    @(negedge clk_100);
    check("t1_valid", pixel_valid_a, 1'b1);
    check("t1_data", pixel_data_a, 24'h112233);
    drive(0, 8'h00, 0, 1);
    @(negedge clk_100);
    check("t1_popped", pixel_valid_a, 1'b0);

    // BGR arrival order.
    drive(1, 8'hAA, 0, 1);
    drive(1, 8'hBB, 0, 1);
    drive(1, 8'hCC, 0, 1);
    drive(0, 8'h00, 0, 1);
    @(negedge clk_100);
    check("t2_data_bgr", pixel_data_b, 24'hCCBBAA);
    check("t2_data_rgb", pixel_data_a, 24'hAABBCC);

    // Fill to 16 with the sink stalled, then back-pressure at phase 2.
    for (int p = 0; p < 16; p++)
      for (int k = 0; k < 3; k++)
        drive(1, 8'(p * 3 + k + 1), 0, 0);
    drive(0, 8'h00, 0, 0);
    @(negedge clk_100);
    check("t3_level_full", fifo_level_a, 5'd16);
    check("t3_ready_ph0", byte_ready_a, 1'b1);
    drive(1, 8'hE1, 0, 0);
    drive(1, 8'hE2, 0, 0);
    drive(1, 8'hE3, 0, 0);
    @(negedge clk_100);
    check("t3_ready_ph2_full", byte_ready_a, 1'b0);
    drive(1, 8'hE3, 0, 1);
    drive(1, 8'hE3, 0, 1);
    @(negedge clk_100);
    check("t3_ready_after_pop", byte_ready_a, 1'b1);
    drive(0, 8'h00, 0, 1);
    repeat (20) drive(0, 8'h00, 0, 1);

    // Partial pixel dropped by byte_sof.
    drive(1, 8'h01, 0, 0);
    drive(1, 8'h02, 0, 0);
    drive(1, 8'h10, 1, 0);
    drive(1, 8'h20, 0, 0);
    drive(1, 8'h30, 0, 0);
    drive(0, 8'h00, 0, 0);
    @(negedge clk_100);
    check("t4_deb", deb_a, 8'd1);
    check("t4_level", fifo_level_a, 5'd1);
    check("t4_data", pixel_data_a, 24'h102030);
    check("t4_sof", pixel_sof_a, 1'b1);

    // byte_sof at phase 0 drops nothing; only the first pixel of the frame is marked.
    drive(1, 8'h40, 1, 0);
    drive(1, 8'h50, 0, 0);
    drive(1, 8'h60, 0, 0);
    drive(1, 8'h70, 0, 0);
    drive(1, 8'h80, 0, 0);
    drive(1, 8'h90, 0, 0);
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 0);
    @(negedge clk_100);
    check("t5_deb", deb_a, 8'd1);
    check("t5_first_data", pixel_data_a, 24'h405060);
    check("t5_first_sof", pixel_sof_a, 1'b1);
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 0);
    @(negedge clk_100);
    check("t5_next_data", pixel_data_a, 24'h708090);
    check("t5_next_sof", pixel_sof_a, 1'b0);
    repeat (5) drive(0, 8'h00, 0, 1);

    // Random traffic: slow sink first, then fast sink.
    repeat (1500) drive($urandom_range(0, 3) != 0, 8'($urandom),
                        $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    repeat (1500) drive($urandom_range(0, 3) != 0, 8'($urandom),
                        $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    repeat (40) drive(0, 8'h00, 0, 1);

    // Drop counter saturation.
    repeat (260) begin
      drive(1, 8'($urandom), 0, 1);
      drive(1, 8'($urandom), 1, 1);
    end
    drive(0, 8'h00, 0, 1);
    @(negedge clk_100);
    check("sat_deb", deb_a, 8'hFF);
    repeat (20) drive(0, 8'h00, 0, 1);

    // Async reset with five pixels buffered and a byte held at phase 1.
    drive(1, 8'h01, 1, 0);
    for (int i = 1; i < 16; i++) drive(1, 8'(i + 1), 0, 0);
    drive(0, 8'h00, 0, 0);
    @(negedge clk_100);
    check("t6_level_pre", fifo_level_a, 5'd5);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_valid", pixel_valid_a, 1'b0);
    check("t6_rst_level", fifo_level_a, 5'd0);
    check("t6_rst_ready", byte_ready_a, 1'b0);
    check("t6_rst_deb", deb_a, 8'd0);
    check("t6_rst_data", pixel_data_a, 24'h000000);
    repeat (2) @(posedge clk_100);
    #3 reset = 1'b1;
    drive(1, 8'hA1, 0, 0);
    drive(1, 8'hA2, 0, 0);
    drive(1, 8'hA3, 0, 0);
    drive(0, 8'h00, 0, 0);
    @(negedge clk_100);
    check("t6_post_level", fifo_level_a, 5'd1);
    check("t6_post_data", pixel_data_a, 24'hA1A2A3);
    check("t6_post_sof", pixel_sof_a, 1'b0);
    repeat (3) drive(0, 8'h00, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
